// File: rtl/wb_ledpwm_pkg.sv
// wb_ledpwm_pkg: register map and channel mode encodings
// shared by the wb_ledpwm top level and its channel slices
package wb_ledpwm_pkg;

  localparam logic [7:0] OFF_PRESC     = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h08;
  localparam logic [7:0] OFF_CH_BASE   = 8'h10;
  localparam logic [7:0] OFF_CH_STRIDE = 8'h10;

  localparam logic [3:0] OFF_MODE   = 4'h0;
  localparam logic [3:0] OFF_PERIOD = 4'h4;
  localparam logic [3:0] OFF_DUTY   = 4'h8;
  localparam logic [3:0] OFF_COUNT  = 4'hC;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  function automatic logic mode_runs(mode_e m);
    return (m == MODE_PWM) || (m == MODE_BLINK);
  endfunction

endpackage

// File: rtl/wb_ledpwm_if.sv
// wb_ledpwm_if: Wishbone classic slave bundle for wb_ledpwm
// master drives the request, slave returns data and ack
interface wb_ledpwm_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        we;
  logic        ack;

  modport master (
    output adr, wdat, sel, stb, cyc, we,
    input  rdat, ack
  );

  modport slave (
    input  adr, wdat, sel, stb, cyc, we,
    output rdat, ack
  );
endinterface

// File: rtl/wb_ledpwm_chan.sv
// wb_ledpwm_chan: one LED channel (mode, count, phase, compare)
// WB_LEDPWM_SHADOW_EN: PERIOD/DUTY land in shadows until next wrap
module wb_ledpwm_chan
  import wb_ledpwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             mode_wr,
  input  logic             period_wr,
  input  logic             duty_wr,
  input  logic [CNT_W-1:0] wdat,
  output mode_e            mode,
  output logic [CNT_W-1:0] period_rd,
  output logic [CNT_W-1:0] duty_rd,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic             phase;
  logic             runs;

  assign runs = mode_runs(mode);
  // >= so a shortened PERIOD wraps on the very next tick
  assign wrap = tick & runs & ~mode_wr & (count >= period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode  <= MODE_OFF;
      count <= '0;
      phase <= 1'b0;
    end else if (mode_wr) begin
      mode  <= mode_e'(wdat[1:0]);
      count <= '0;
      phase <= 1'b1;
    end else if (wrap) begin
      count <= '0;
      phase <= ~phase;
    end else if (tick && runs) begin
      count <= count + 1'b1;
    end
  end

`ifdef WB_LEDPWM_SHADOW_EN
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] period_nx;
  logic [CNT_W-1:0] duty_nx;

  assign period_nx = period_wr ? wdat : period_sh;
  assign duty_nx   = duty_wr ? wdat : duty_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_sh <= '0;
      duty_sh   <= '0;
      period    <= '0;
      duty      <= '0;
    end else begin
      period_sh <= period_nx;
      duty_sh   <= duty_nx;
      if (!runs || wrap) begin
        period <= period_nx;
        duty   <= duty_nx;
      end
    end
  end

  assign period_rd = period_sh;
  assign duty_rd   = duty_sh;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      duty   <= '0;
    end else begin
      if (period_wr) period <= wdat;
      if (duty_wr)   duty   <= wdat;
    end
  end

  assign period_rd = period;
  assign duty_rd   = duty;
`endif

  always_comb begin
    active = 1'b0;
    unique case (mode)
      MODE_ON:    active = 1'b1;
      MODE_PWM:   active = count < duty;
      MODE_BLINK: active = phase;
      default:    active = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_ledpwm.sv
// wb_ledpwm: Wishbone LED/PWM controller with CHANNELS channels
// WB_LEDPWM_SHADOW_EN: PERIOD/DUTY double-buffered until the next wrap
module wb_ledpwm
  import wb_ledpwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int PRESC_W    = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  wb_ledpwm_if.slave          wb,
  output logic [CHANNELS-1:0] led_o,
  output logic                intr
);

  logic [7:0]          a;
  logic [7:0]          ch_off;
  logic [3:0]          ch_idx;
  logic [3:0]          ch_reg;
  logic                req;
  logic                wr;
  logic                ch_hit;
  logic                ch_wr;
  logic                tick;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  presc_cnt;
  logic [CHANNELS-1:0] status;
  logic [CHANNELS-1:0] irq_en;
  logic [CHANNELS-1:0] w1c;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] active;
  logic [31:0]         rdata;
  logic [31:0]         ch_rd [16];
  logic                unused_bits;

  assign a       = {wb.adr[7:2], 2'b00};
  assign ch_off  = a - OFF_CH_BASE;
  assign ch_idx  = ch_off[7:4];
  assign ch_reg  = a[3:0];
  assign req     = wb.stb & wb.cyc & ~wb.ack;
  assign wr      = req & wb.we;
  assign ch_hit  = (a >= OFF_CH_BASE) && ({4'd0, ch_idx} < 8'(CHANNELS));
  assign ch_wr   = wr & ch_hit;
  assign tick    = presc_cnt >= presc;
  assign w1c     = (wr && a == OFF_STATUS) ? wb.wdat[CHANNELS-1:0] : '0;
  assign intr    = |(status & irq_en);
  assign unused_bits = ^{wb.sel, wb.adr[31:8], wb.adr[1:0], wb.wdat};

  for (genvar n = 0; n < 16; n++) begin : g_ch
    if (n < CHANNELS) begin : g_on
      logic             hit;
      mode_e            mode;
      logic [CNT_W-1:0] per;
      logic [CNT_W-1:0] duty;
      logic [CNT_W-1:0] cnt;

      assign hit = ch_wr && (ch_idx == 4'(n));

      wb_ledpwm_chan #(.CNT_W(CNT_W)) u_chan (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .mode_wr   (hit && ch_reg == OFF_MODE),
        .period_wr (hit && ch_reg == OFF_PERIOD),
        .duty_wr   (hit && ch_reg == OFF_DUTY),
        .wdat      (wb.wdat[CNT_W-1:0]),
        .mode      (mode),
        .period_rd (per),
        .duty_rd   (duty),
        .count     (cnt),
        .wrap      (wrap[n]),
        .active    (active[n])
      );

      assign ch_rd[n] =
        (ch_reg == OFF_MODE)   ? 32'(mode) :
        (ch_reg == OFF_PERIOD) ? 32'(per)  :
        (ch_reg == OFF_DUTY)   ? 32'(duty) :
                                 32'(cnt);
    end else begin : g_off
      assign ch_rd[n] = '0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a == OFF_PRESC:  rdata = 32'(presc);
      a == OFF_STATUS: rdata = 32'(status);
      a == OFF_IRQ_EN: rdata = 32'(irq_en);
      ch_hit:          rdata = ch_rd[ch_idx];
      default:         rdata = '0;
    endcase
  end

  // a wrap wins over a W1C to the same STATUS bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.ack    <= 1'b0;
      wb.rdat   <= '0;
      presc     <= '0;
      presc_cnt <= '0;
      irq_en    <= '0;
      status    <= '0;
      led_o     <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      wb.ack <= req;
      if (req) wb.rdat <= rdata;
      if (wr && a == OFF_PRESC)  presc  <= wb.wdat[PRESC_W-1:0];
      if (wr && a == OFF_IRQ_EN) irq_en <= wb.wdat[CHANNELS-1:0];
      status    <= (status & ~w1c) | wrap;
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      led_o     <= active ^ {CHANNELS{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_wb_ledpwm.sv
// tb_wb_ledpwm: randomized bench for wb_ledpwm against a tick-count model
// channel state is modelled as ticks elapsed since the last MODE write
module tb_wb_ledpwm;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] led_o;
  logic           intr;

  wb_ledpwm_if bus ();

  wb_ledpwm #(
    .CHANNELS   (NCH),
    .CNT_W      (16),
    .PRESC_W    (16),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus),
    .led_o (led_o),
    .intr  (intr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  bit mdl_on = 1'b1;
  logic prev_led0;
  int fall_q[$];

  int m_presc, m_pc, m_irq, m_status;
  int m_mode [NCH];
  int m_per  [NCH];
  int m_duty [NCH];
  int m_n    [NCH];
  logic [NCH-1:0] m_led;
  bit pw_valid;
  int pw_a;
  int unsigned pw_d;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic int m_cnt(int c);
    if (m_mode[c] < 2) return 0;
    return m_n[c] % (m_per[c] + 1);
  endfunction

  function automatic bit m_act(int c);
    case (m_mode[c])
      1: return 1'b1;
      2: return m_cnt(c) < m_duty[c];
      3: return ((m_n[c] / (m_per[c] + 1)) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned m_read(int a);
    int c;
    if (a == 0) return m_presc;
    if (a == 4) return m_status;
    if (a == 8) return m_irq;
    if (a < 16) return 0;
    c = (a - 16) >> 4;
    if (c >= NCH) return 0;
    case (a & 12)
      0: return m_mode[c];
      4: return m_per[c];
      8: return m_duty[c];
      default: return m_cnt(c);
    endcase
  endfunction

  function automatic void m_clear();
    m_presc = 0; m_pc = 0; m_irq = 0; m_status = 0;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_n[i] = 0;
    end
    m_led = '1;
    pw_valid = 1'b0;
  endfunction

  function automatic void m_edge();
    bit tk;
    int mw;
    int wraps;
    int c;
    for (int i = 0; i < NCH; i++) m_led[i] = ~m_act(i);
    tk = (m_pc == m_presc);
    m_pc = tk ? 0 : m_pc + 1;
    c = (pw_a - 16) >> 4;
    mw = (pw_valid && pw_a >= 16 && c < NCH && (pw_a & 12) == 0) ? c : -1;
    wraps = 0;
    for (int i = 0; i < NCH; i++) begin
      if (i != mw && m_mode[i] >= 2 && tk) begin
        m_n[i]++;
        if (m_n[i] % (m_per[i] + 1) == 0) wraps |= (1 << i);
      end
    end
    if (pw_valid) begin
      if (pw_a == 0) m_presc = int'(pw_d & 32'hFFFF);
      else if (pw_a == 8) m_irq = int'(pw_d & 15);
      else if (pw_a >= 16 && c < NCH) begin
        case (pw_a & 12)
          0: begin m_mode[c] = int'(pw_d & 3); m_n[c] = 0; end
          4: m_per[c]  = int'(pw_d & 32'hFFFF);
          8: m_duty[c] = int'(pw_d & 32'hFFFF);
          default: ;
        endcase
      end
    end
    if (pw_valid && pw_a == 4) m_status = m_status & ~int'(pw_d);
    m_status = (m_status | wraps) & 15;
  endfunction

  task automatic step();
    @(posedge clk);
    if (mdl_on) m_edge();
    pw_valid = 1'b0;
    cyc_n++;
    @(negedge clk);
    if (led_o[0] === 1'b0 && prev_led0 === 1'b1) fall_q.push_back(cyc_n);
    prev_led0 = led_o[0];
    if (mdl_on) begin
      check("led", led_o, m_led);
      check("intr", intr, (m_status & m_irq) != 0);
    end
  endtask

  task automatic wb_wr(input int a, input int unsigned d);
    bus.adr  = ($urandom() & 32'hFFFF_FF00) | 32'(a) | ($urandom() & 3);
    bus.wdat = d;
    bus.sel  = 4'($urandom());
    bus.we   = 1'b1;
    bus.stb  = 1'b1;
    bus.cyc  = 1'b1;
    pw_valid = 1'b1;
    pw_a     = a;
    pw_d     = d;
    step();
    check("wr_ack", bus.ack, 1);
    bus.stb = 1'b0;
    bus.cyc = 1'b0;
    bus.we  = 1'b0;
    step();
    check("wr_ack_drop", bus.ack, 0);
  endtask

  task automatic wb_rd(input int a, output int unsigned d, output int unsigned e);
    bus.adr = ($urandom() & 32'hFFFF_FF00) | 32'(a) | ($urandom() & 3);
    bus.sel = 4'hF;
    bus.we  = 1'b0;
    bus.stb = 1'b1;
    bus.cyc = 1'b1;
    e = m_read(a);
    step();
    check("rd_ack", bus.ack, 1);
    d = bus.rdat;
    bus.stb = 1'b0;
    bus.cyc = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.stb = 1'b0;
    bus.cyc = 1'b0;
    bus.we  = 1'b0;
    #1;
    check("rst_led", led_o, 4'hF);
    check("rst_intr", intr, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_dat", bus.rdat, 0);
    m_clear();
    @(negedge clk);
    reset = 1'b0;
    prev_led0 = led_o[0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d, e;
    int cnt, r, c, r1, r2, n_pre, last_pre, w_cyc;
    bit seen;

    bus.adr = '0; bus.wdat = '0; bus.sel = '0;
    bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0;
    reset = 1'b1;
    m_clear();

    // reset state and full register readback
    do_reset();
    for (int a = 0; a < 'h50; a += 4) begin
      wb_rd(a, d, e);
      check("rst_reg", d, 0);
    end

    // PWM 150/600
    do_reset();
    wb_wr('h14, 599);
    wb_wr('h18, 150);
    wb_wr('h10, 2);
    cnt = 0;
    repeat (600) begin
      step();
      if (led_o[0] == 1'b0) cnt++;
    end
    check("pwm_low_clocks", cnt, 150);
    repeat (700) step();
    wb_rd(4, d, e);
    check("pwm_status", d, e);
    check("pwm_status_set", d & 1, 1);

    // blink with interrupt
    do_reset();
    wb_wr(0, 4);
    wb_wr('h24, 9);
    wb_wr(8, 2);
    wb_wr('h20, 3);
    seen = 0;
    r1 = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (intr) begin seen = 1; r1 = cyc_n; end
    end
    check("blink_irq_rise", seen, 1);
    wb_wr(4, 2);
    check("irq_cleared", intr, 0);
    seen = 0;
    r2 = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (intr) begin seen = 1; r2 = cyc_n; end
    end
    check("irq_reassert_seen", seen, 1);
    check("irq_reassert_gap", r2 - r1, 50);

    // DUTY=0: never active
    do_reset();
    wb_wr('h14, 9);
    wb_wr('h18, 0);
    wb_wr('h10, 2);
    cnt = 0;
    repeat (40) begin
      step();
      if (led_o[0] == 1'b1) cnt++;
    end
    check("duty0_high", cnt, 40);

    // DUTY=PERIOD+1: always active
    do_reset();
    wb_wr('h14, 9);
    wb_wr('h18, 10);
    wb_wr('h10, 2);
    cnt = 0;
    repeat (40) begin
      step();
      if (led_o[0] == 1'b0) cnt++;
    end
    check("duty_full_low", cnt, 40);

    // W1C landing on the wrap edge
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (m_pc == m_presc && (m_n[0] + 1) % (m_per[0] + 1) == 0) seen = 1;
      else step();
    end
    check("collide_aligned", seen, 1);
    wb_wr(4, 1);
    wb_rd(4, d, e);
    check("w1c_collide", d & 1, 1);
    check("w1c_collide_mdl", d, e);
    wb_wr(4, 1);
    wb_rd(4, d, e);
    check("w1c_clear", d & 1, 0);

    // randomized configurations
    repeat (4) begin
      do_reset();
      wb_wr(0, $urandom_range(0, 3));
      for (int i = 0; i < NCH; i++) begin
        wb_wr(16 * i + 20, $urandom_range(0, 12));
        wb_wr(16 * i + 24, $urandom_range(0, 14));
      end
      wb_wr(8, $urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) wb_wr(16 * i + 16, $urandom_range(0, 3));
      for (int i = 0; i < 250; i++) begin
        r = $urandom_range(0, 11);
        c = $urandom_range(0, NCH - 1);
        if (r == 0) wb_wr(4, $urandom_range(0, 15));
        else if (r == 1) wb_wr(16 * c + 16, $urandom_range(0, 3));
        else if (r == 2) wb_wr('h0C, $urandom());
        else if (r <= 4) begin
          wb_rd($urandom_range(0, 63) * 4, d, e);
          check("rand_rd", d, e);
        end else step();
      end
    end

    // PERIOD 599 -> 99 while COUNT is past 99
    do_reset();
    mdl_on = 1'b0;
    wb_wr('h14, 599);
    wb_wr('h18, 50);
    wb_wr('h10, 2);
    fall_q.delete();
    repeat (900) step();
    n_pre = fall_q.size();
    last_pre = (n_pre > 0) ? fall_q[n_pre - 1] : 0;
    wb_wr('h14, 99);
    w_cyc = cyc_n;
`ifdef WB_LEDPWM_SHADOW_EN
    repeat (800) step();
    check("shadow_falls", fall_q.size() >= n_pre + 2, 1);
    if (fall_q.size() >= n_pre + 2) begin
      check("shadow_old_period", fall_q[n_pre] - last_pre, 600);
      check("shadow_new_period", fall_q[n_pre + 1] - fall_q[n_pre], 100);
    end
`else
    repeat (300) step();
    check("direct_falls", fall_q.size() >= n_pre + 2, 1);
    if (fall_q.size() >= n_pre + 2) begin
      check("direct_wrap_next", fall_q[n_pre] - w_cyc, 1);
      check("direct_new_period", fall_q[n_pre + 1] - fall_q[n_pre], 100);
    end
`endif
    mdl_on = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
